crc_frame_arbiter: RTL and testbench

- Shares one byte-wide CRC-16 datapath among N framed byte-stream requesters.
- Arbitrates per frame (round-robin) and passes the granted frame's payload to a single output stream.
- Computes CRC-16 over the payload and appends the two CRC bytes, MSB first, before releasing the grant.
- Sits between packet sources and the serial link framer.

---
 rtl/crc_frame_pkg.sv | 34 +++
 rtl/crc_frame_arbiter_rr_arbiter.sv | 31 +++
 rtl/crc_frame_arbiter.sv | 115 +++++++++++
 tb/tb_crc_frame_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_frame_pkg.sv
// Shared types and the CRC-16 bytewise update for the frame arbiter.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC_HI  = 2'd2,
        CRC_LO  = 2'd3
    } state_t;

    localparam logic [15:0] POLY_SEL0 = 16'h0003;  // x^16+x+1
    localparam logic [15:0] POLY_SEL1 = 16'h1021;  // x^16+x^12+x^5+1
    localparam logic [15:0] POLY_SELX = 16'h8005;  // x^16+x^15+x^2+1

    // One byte of MSB-first CRC-16, no reflection, no final XOR.
    function automatic logic [15:0] crc16_step(input int crc_sel,
                                               input logic [7:0] data,
                                               input logic [15:0] crc);
        logic [15:0] poly;
        logic [15:0] c;
        case (crc_sel)
            0:       poly = POLY_SEL0;
            1:       poly = POLY_SEL1;
            default: poly = POLY_SELX;
        endcase
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ poly;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_frame_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    localparam int unsigned IW = $clog2(N);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/crc_frame_arbiter.sv
// Per-frame round-robin sharing of one CRC-16 datapath; appends CRC (MSB first) to each frame.
module crc_frame_arbiter
    import crc_frame_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int          CRC_SEL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         s_valid,
    input  logic [N_REQ*8-1:0]       s_data,
    input  logic [N_REQ-1:0]         s_last,
    output logic [N_REQ-1:0]         s_ready,
    output logic                     m_valid,
    output logic [7:0]               m_data,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);
    localparam int unsigned IW = $clog2(N_REQ);

    state_t        state, state_nxt;
    logic [15:0]   crc;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic          arb_valid;
    logic [7:0]    s_byte [N_REQ];
    logic          cur_valid, cur_last, pay_hs;
    logic [7:0]    cur_data;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign s_byte[i] = s_data[8*i +: 8];
    end

    assign cur_valid = s_valid[grant];
    assign cur_last  = s_last[grant];
    assign cur_data  = s_byte[grant];
    assign pay_hs    = (state == PAYLOAD) && cur_valid && m_ready;
    assign arb_valid = |arb_gnt;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req (s_valid),
        .ptr (rr_ptr),
        .en  (state == IDLE),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid)           state_nxt = PAYLOAD;
            PAYLOAD: if (pay_hs && cur_last)  state_nxt = CRC_HI;
            CRC_HI:  if (m_ready)             state_nxt = CRC_LO;
            CRC_LO:  if (m_ready)             state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Payload is a combinational pass-through; CRC bytes come from the held register.
    always_comb begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_last  = 1'b0;
        s_ready = '0;
        case (state)
            PAYLOAD: begin
                m_valid        = cur_valid;
                m_data         = cur_data;
                s_ready[grant] = m_ready;
            end
            CRC_HI: begin
                m_valid = 1'b1;
                m_data  = crc[15:8];
            end
            CRC_LO: begin
                m_valid = 1'b1;
                m_data  = crc[7:0];
                m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc       <= 16'h0000;
            grant     <= '0;
            busy      <= 1'b0;
            frame_cnt <= 16'h0000;
            rr_ptr    <= IW'(N_REQ - 1);
        end else begin
            if (state == IDLE && arb_valid) begin
                grant <= arb_idx;
                crc   <= 16'h0000;
                busy  <= 1'b1;
            end
            if (pay_hs) crc <= crc16_step(CRC_SEL, cur_data, crc);
            if (state == CRC_LO && m_ready) begin
                rr_ptr    <= grant;
                frame_cnt <= frame_cnt + 16'd1;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Randomized scoreboard bench: per-requester expected byte queues, frame-level round-robin model.
module tb_crc_frame_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     s_valid, s_last, s_ready;
    logic [N*8-1:0]   s_data;
    logic             m_valid, m_last, m_ready;
    logic [7:0]       m_data;
    logic [IW-1:0]    grant;
    logic             busy;
    logic [15:0]      frame_cnt;

    always #5 clk = ~clk;

    crc_frame_arbiter #(.N_REQ(N), .CRC_SEL(1)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] src_q [N][$];
    logic [8:0] exp_q [N][$];
    logic [7:0] frame_buf [$];
    int rdy_rand = 0;
    int gap_pct  = 0;
    int hs_total = 0;
    logic mon_idle = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC as remainder of (message * x^16) mod P by long division over the bit stream.
    function automatic logic [15:0] ref_crc();
        logic [16:0] rem;
        logic [7:0]  byt;
        logic        b_in;
        int          nbits;
        rem   = '0;
        nbits = frame_buf.size() * 8;
        for (int b = 0; b < nbits + 16; b++) begin
            if (b < nbits) begin
                byt  = frame_buf[b / 8];
                b_in = byt[7 - (b % 8)];
            end else begin
                b_in = 1'b0;
            end
            rem = {rem[15:0], b_in};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic queue_frame(input int r, input logic use_exp, input logic [15:0] exp_crc);
        logic [15:0] c;
        logic        lst;
        c = use_exp ? exp_crc : ref_crc();
        for (int i = 0; i < frame_buf.size(); i++) begin
            lst = (i == frame_buf.size() - 1);
            src_q[r].push_back({lst, frame_buf[i]});
            exp_q[r].push_back({1'b0, frame_buf[i]});
        end
        exp_q[r].push_back({1'b0, c[15:8]});
        exp_q[r].push_back({1'b1, c[7:0]});
    endtask

    task automatic set_ascii();
        frame_buf = {};
        for (int c = 8'h31; c <= 8'h39; c++) frame_buf.push_back(8'(c));
    endtask

    function automatic logic all_empty();
        logic e;
        e = mon_idle;
        for (int i = 0; i < N; i++)
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (!all_empty() && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(all_empty()), 32'd1);
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Source and sink driver: sample handshakes at negedge, update just after posedge.
    initial begin
        logic [N-1:0] hs;
        logic [8:0]   fr;
        s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b0;
        forever begin
            @(negedge clk);
            hs = rst ? '0 : (s_valid & s_ready);
            @(posedge clk);
            #1;
            m_ready = (rdy_rand != 0) ? ($urandom_range(0, 99) < 60) : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (s_valid[i] && !hs[i]) begin
                    // hold the presented byte until accepted
                end else if (src_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                    fr = src_q[i][0];
                    s_valid[i]       = 1'b1;
                    s_data[8*i +: 8] = fr[7:0];
                    s_last[i]        = fr[8];
                end else begin
                    s_valid[i]       = 1'b0;
                    s_last[i]        = 1'b0;
                    s_data[8*i +: 8] = 8'($urandom);
                end
            end
        end
    end

    // Monitor: frame-level arbitration model plus byte scoreboard.
    initial begin
        int          owner, rr_model;
        logic [IW-1:0] last_grant;
        logic [15:0] frames;
        logic        grant_chk, prev_stall, after_rst;
        logic [8:0]  prev_out, e;
        logic [N-1:0] omask;
        owner = 0; rr_model = N - 1; last_grant = '0; frames = '0;
        grant_chk = 1'b0; prev_stall = 1'b0; after_rst = 1'b1; prev_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_idle = 1'b1; rr_model = N - 1; last_grant = '0; frames = '0;
                grant_chk = 1'b0; prev_stall = 1'b0; after_rst = 1'b1;
            end else if (mon_idle) begin
                chk("idle_m_valid", 32'(m_valid), 32'd0);
                chk("idle_s_ready", 32'(s_ready), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_grant", 32'(grant), 32'(last_grant));
                chk("frame_cnt", 32'(frame_cnt), 32'(frames));
                if (after_rst) begin
                    chk("rst_m_data", 32'(m_data), 32'd0);
                    chk("rst_m_last", 32'(m_last), 32'd0);
                    after_rst = 1'b0;
                end
                if (|s_valid) begin
                    owner     = pick(s_valid, rr_model);
                    mon_idle  = 1'b0;
                    grant_chk = 1'b1;
                end
                prev_stall = 1'b0;
            end else begin
                if (grant_chk) begin
                    chk("grant", 32'(grant), 32'(owner));
                    chk("busy", 32'(busy), 32'd1);
                    grant_chk = 1'b0;
                end
                omask = N'(1) << owner;
                chk("s_ready_other", 32'(s_ready & ~omask), 32'd0);
                if (prev_stall) begin
                    chk("hold_valid", 32'(m_valid), 32'd1);
                    chk("hold_data", 32'({m_last, m_data}), 32'(prev_out));
                end
                if (m_valid && m_ready) begin
                    hs_total++;
                    if (exp_q[owner].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h with no expected byte for req %0d", {m_last, m_data}, owner);
                    end else begin
                        e = exp_q[owner].pop_front();
                        chk("out_byte", 32'({m_last, m_data}), 32'(e));
                        if (e[8]) begin
                            mon_idle   = 1'b1;
                            rr_model   = owner;
                            last_grant = IW'(owner);
                            frames     = frames + 16'd1;
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_out   = {m_last, m_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start, n, r, len;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Contention right after reset: req0 then req1.
        set_ascii();
        queue_frame(0, 1'b1, 16'h31C3);
        frame_buf = {8'h01};
        queue_frame(1, 1'b1, 16'h1021);
        drain(200);

        // Fairness: req0 re-requests at once while req1 waits.
        set_ascii();
        queue_frame(0, 1'b1, 16'h31C3);
        frame_buf = {8'h01};
        queue_frame(0, 1'b1, 16'h1021);
        frame_buf = {8'hA5, 8'h5A};
        queue_frame(1, 1'b0, 16'h0000);
        drain(300);

        // Backpressure on the output.
        rdy_rand = 1;
        set_ascii();
        queue_frame(3, 1'b1, 16'h31C3);
        drain(400);

        // Random traffic with source gaps.
        gap_pct = 30;
        for (int f = 0; f < 40; f++) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 12);
            frame_buf = {};
            for (int i = 0; i < len; i++) frame_buf.push_back(8'($urandom));
            queue_frame(r, 1'b0, 16'h0000);
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        drain(6000);

        // Reset in the middle of a frame, then a clean frame from req2.
        rdy_rand = 0;
        gap_pct  = 0;
        set_ascii();
        queue_frame(2, 1'b1, 16'h31C3);
        start = hs_total;
        n = 0;
        while (hs_total < start + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_wait", 32'(hs_total >= start + 4), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        s_valid = '0;
        s_last  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        set_ascii();
        queue_frame(2, 1'b1, 16'h31C3);
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
